vga_rect_fill_ctrl: RTL and testbench
=====================================

// Module: vga_rect_fill_ctrl
// PURPOSE
//  Rectangle-fill controller for the 160x120 12-bit VGA framebuffer.
//  Sits between the MMIO decode and the framebuffer write port (WE/WA/WD).
//  The CPU loads geometry/colour registers and issues GO; the block then writes one pixel per cycle.
//  It shares the framebuffer write port with direct CPU pixel writes; CPU pixel writes have strict priority.
// PARAMETERS
//  FB_W   160  framebuffer width in pixels (x range 0..FB_W-1)
//  FB_H   120  framebuffer height in pixels (y range 0..FB_H-1)
// PORTS
//  CLK         in   1   system clock (50 MHz domain)
//  RST_N       in   1   asynchronous, active-low reset
//  CFG_WE      in   1   register write strobe
//  CFG_SEL     in   3   0:X0[7:0] 1:Y0[6:0] 2:W[7:0] 3:H[6:0] 4:COLOR[11:0] 5:CTRL(b0 GO, b1 ABORT)
//  CFG_WD      in   16  register write data (unused high bits ignored)
//  CPU_PIX_WE  in   1   direct CPU pixel write request
//  CPU_PIX_WA  in   15  direct write address {y[6:0],x[7:0]}
//  CPU_PIX_WD  in   12  direct write colour
//  FB_WE       out  1   framebuffer write enable (registered)
//  FB_WA       out  15  framebuffer address {y[6:0],x[7:0]} (registered)
//  FB_WD       out  12  framebuffer colour (registered)
//  BUSY        out  1   fill in progress (SETUP or FILL)
//  PIX_CNT     out  15  pixels written by engine in current/last fill
//  DONE_IRQ    out  1   completion pulse (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; X0/Y0/W/H/COLOR regs 0; state IDLE.
//  Config regs are writable at any time; a fill uses copies latched at GO, so mid-fill writes affect only the next fill.
//  States and transitions:
//   - IDLE -> SETUP on CTRL write with GO=1; latch regs and clear PIX_CNT. GO in any other state is ignored.
//   - SETUP (1 cycle): x_end = min(X0+W, FB_W)-1 and y_end = min(Y0+H, FB_H)-1, with 9-bit sums.
//     Empty rectangle (W==0, H==0, X0>=FB_W or Y0>=FB_H) -> DONE; otherwise -> FILL with cursor=(X0,Y0).
//   - FILL: row-major walk, x fastest. Emit cursor pixel in every cycle with CPU_PIX_WE=0.
//     After emitting (x_end,y_end) -> DONE.
//   - DONE (1 cycle): BUSY=0, DONE_IRQ pulse -> IDLE.
//  ABORT=1 in a CTRL write during SETUP/FILL -> DONE next cycle; no further engine writes; PIX_CNT holds its count.
//   GO and ABORT set together: ABORT wins (no fill starts).
//  Arbitration: CPU_PIX_WE=1 in any state forwards the CPU address/colour to FB_* next cycle.
//   Engine cursor stalls that cycle: no pixel is lost or duplicated.
//  Latency: FB_* updates 1 cycle after the grant decision. BUSY rises the cycle after the GO write.
//  Engine writes never address x>=FB_W or y>=FB_H (clipping).
//  FB_WE=0 whenever neither source writes.
//  PIX_CNT increments once per engine pixel; max 160*120=19200 fits in 15 bits.
// CONFIGURATION
//  VGA_FILL_IRQ_EN defined: DONE_IRQ is a 1-cycle high pulse on DONE entry (including aborts and empty fills).
//  Not defined: DONE_IRQ tied 0 and no IRQ logic is synthesized; software polls BUSY.
// STRUCTURE
//  Package vga_fill_pkg: FB_W/FB_H defaults, CFG_SEL constants, CTRL bit positions, state enum.
//   Also holds the pixel-address pack function {y,x}.
//  Sub-module vga_rect_walker: x/y cursor with load/advance/stall and last-pixel flag.
// TESTING
//  1 Reset asserted mid-FILL -> all outputs 0 immediately, state IDLE, no FB_WE after release.
//  2 X0=10 Y0=5 W=3 H=2 COLOR=F00, GO -> 6 writes:
//     0x050A,0x050B,0x050C,0x060A,0x060B,0x060C, all WD=F00; PIX_CNT=6; BUSY high 7 cycles.
//  3 X0=158 Y0=119 W=5 H=4 -> exactly 2 writes (0x779E, 0x779F); PIX_CNT=2.
//  4 CPU_PIX_WE for 3 cycles mid-fill (WA=0x0000, WD=0FF) -> those 3 FB writes carry the CPU values.
//     Engine sequence resumes gap-free; total engine writes unchanged.
//  5 ABORT after 4 engine pixels -> no further engine writes, PIX_CNT=4, DONE_IRQ pulse (macro on).
//     GO during FILL is ignored.
//  6 W=0 -> BUSY high 1 cycle, zero FB writes, DONE_IRQ pulse; same run with macro off -> DONE_IRQ stays 0.

Source files
------------

// File: rtl/vga_fill_pkg.sv
// Shared constants, state encoding and address packing for the VGA rectangle-fill controller.
package vga_fill_pkg;

  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;

  localparam logic [2:0] SEL_X0    = 3'd0;
  localparam logic [2:0] SEL_Y0    = 3'd1;
  localparam logic [2:0] SEL_W     = 3'd2;
  localparam logic [2:0] SEL_H     = 3'd3;
  localparam logic [2:0] SEL_COLOR = 3'd4;
  localparam logic [2:0] SEL_CTRL  = 3'd5;

  localparam int CTRL_GO_BIT    = 0;
  localparam int CTRL_ABORT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  function automatic logic [14:0] pix_addr(input logic [6:0] y, input logic [7:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_rect_walker.sv
// Row-major x/y cursor for the fill engine: load, advance (x fastest) or hold, plus last-pixel flag.
module vga_rect_walker (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] x_start,
  input  logic [6:0] y_start,
  input  logic [7:0] x_end,
  input  logic [6:0] y_end,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [7:0] xs_q;
  logic [7:0] xe_q;
  logic [6:0] ye_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q  <= '0;
      y_q  <= '0;
      xs_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
    end else if (load) begin
      x_q  <= x_start;
      y_q  <= y_start;
      xs_q <= x_start;
      xe_q <= x_end;
      ye_q <= y_end;
    end else if (advance) begin
      if (x_q == xe_q) begin
        x_q <= xs_q;
        y_q <= y_q + 7'd1;
      end else begin
        x_q <= x_q + 8'd1;
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/vga_rect_fill_ctrl.sv
// Rectangle-fill engine sharing the framebuffer write port with direct CPU pixel writes (CPU wins).
// Define VGA_FILL_IRQ_EN to build the DONE_IRQ completion pulse; otherwise DONE_IRQ is tied low.
module vga_rect_fill_ctrl
  import vga_fill_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CFG_WE,
  input  logic [2:0]  CFG_SEL,
  input  logic [15:0] CFG_WD,
  input  logic        CPU_PIX_WE,
  input  logic [14:0] CPU_PIX_WA,
  input  logic [11:0] CPU_PIX_WD,
  output logic        FB_WE,
  output logic [14:0] FB_WA,
  output logic [11:0] FB_WD,
  output logic        BUSY,
  output logic [14:0] PIX_CNT,
  output logic        DONE_IRQ
);

  localparam logic [8:0] FB_W9 = 9'(FB_W);
  localparam logic [8:0] FB_H9 = 9'(FB_H);

  fill_state_t state;

  logic [7:0]  x0_r, w_r, x0_l, w_l;
  logic [6:0]  y0_r, h_r, y0_l, h_l;
  logic [11:0] color_r, color_l;

  logic        fb_we_q;
  logic [14:0] fb_wa_q;
  logic [11:0] fb_wd_q;
  logic        busy_q;
  logic [14:0] pix_cnt_q;

  logic        ctrl_wr, go, abort;
  logic [8:0]  sum_x, sum_y, xe9, ye9;
  logic [7:0]  x_end;
  logic [6:0]  y_end;
  logic        empty;
  logic        eng_emit, enter_done;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic        cur_last;
  logic        cfg_unused;

  assign cfg_unused = ^CFG_WD[15:12];

  always_comb begin
    ctrl_wr = CFG_WE && (CFG_SEL == SEL_CTRL);
    abort   = ctrl_wr && CFG_WD[CTRL_ABORT_BIT];
    go      = ctrl_wr && CFG_WD[CTRL_GO_BIT] && !CFG_WD[CTRL_ABORT_BIT];

    sum_x = {1'b0, x0_l} + {1'b0, w_l};
    sum_y = {2'b00, y0_l} + {2'b00, h_l};
    xe9   = (sum_x > FB_W9) ? FB_W9 : sum_x;
    ye9   = (sum_y > FB_H9) ? FB_H9 : sum_y;
    x_end = 8'(xe9 - 9'd1);
    y_end = 7'(ye9 - 9'd1);
    empty = (w_l == '0) || (h_l == '0) ||
            ({1'b0, x0_l} >= FB_W9) || ({2'b00, y0_l} >= FB_H9);

    // A CPU write or an abort in the same cycle keeps the cursor where it is.
    eng_emit = (state == ST_FILL) && !CPU_PIX_WE && !abort;

    enter_done = 1'b0;
    case (state)
      ST_SETUP: enter_done = abort || empty;
      ST_FILL:  enter_done = abort || (eng_emit && cur_last);
      default:  enter_done = 1'b0;
    endcase
  end

  vga_rect_walker u_walker (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .load    (state == ST_SETUP),
    .advance (eng_emit),
    .x_start (x0_l),
    .y_start (y0_l),
    .x_end   (x_end),
    .y_end   (y_end),
    .x       (cur_x),
    .y       (cur_y),
    .last    (cur_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x0_r      <= '0;
      y0_r      <= '0;
      w_r       <= '0;
      h_r       <= '0;
      color_r   <= '0;
      x0_l      <= '0;
      y0_l      <= '0;
      w_l       <= '0;
      h_l       <= '0;
      color_l   <= '0;
      state     <= ST_IDLE;
      fb_we_q   <= 1'b0;
      fb_wa_q   <= '0;
      fb_wd_q   <= '0;
      busy_q    <= 1'b0;
      pix_cnt_q <= '0;
    end else begin
      if (CFG_WE) begin
        case (CFG_SEL)
          SEL_X0:    x0_r    <= CFG_WD[7:0];
          SEL_Y0:    y0_r    <= CFG_WD[6:0];
          SEL_W:     w_r     <= CFG_WD[7:0];
          SEL_H:     h_r     <= CFG_WD[6:0];
          SEL_COLOR: color_r <= CFG_WD[11:0];
          default:   ;
        endcase
      end

      fb_we_q <= 1'b0;
      if (CPU_PIX_WE) begin
        fb_we_q <= 1'b1;
        fb_wa_q <= CPU_PIX_WA;
        fb_wd_q <= CPU_PIX_WD;
      end else if (eng_emit) begin
        fb_we_q <= 1'b1;
        fb_wa_q <= pix_addr(cur_y, cur_x);
        fb_wd_q <= color_l;
      end

      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= ST_SETUP;
            busy_q    <= 1'b1;
            pix_cnt_q <= '0;
            x0_l      <= x0_r;
            y0_l      <= y0_r;
            w_l       <= w_r;
            h_l       <= h_r;
            color_l   <= color_r;
          end
        end
        ST_SETUP: begin
          if (enter_done) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
          end else begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (eng_emit) pix_cnt_q <= pix_cnt_q + 15'd1;
          if (enter_done) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_FILL_IRQ_EN
  logic irq_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) irq_q <= 1'b0;
    else        irq_q <= enter_done;
  end

  assign DONE_IRQ = irq_q;
`else
  assign DONE_IRQ = 1'b0;
`endif

  assign FB_WE   = fb_we_q;
  assign FB_WA   = fb_wa_q;
  assign FB_WD   = fb_wd_q;
  assign BUSY    = busy_q;
  assign PIX_CNT = pix_cnt_q;

endmodule

// File: tb/tb_vga_rect_fill_ctrl.sv
// Scoreboard bench for vga_rect_fill_ctrl: expected FB writes queued by stimulus, popped by a monitor.
module tb_vga_rect_fill_ctrl;
  import vga_fill_pkg::*;

`ifdef VGA_FILL_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CFG_WE;
  logic [2:0]  CFG_SEL;
  logic [15:0] CFG_WD;
  logic        CPU_PIX_WE;
  logic [14:0] CPU_PIX_WA;
  logic [11:0] CPU_PIX_WD;
  logic        FB_WE;
  logic [14:0] FB_WA;
  logic [11:0] FB_WD;
  logic        BUSY;
  logic [14:0] PIX_CNT;
  logic        DONE_IRQ;

  vga_rect_fill_ctrl #(.FB_W(160), .FB_H(120)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .CFG_WE     (CFG_WE),
    .CFG_SEL    (CFG_SEL),
    .CFG_WD     (CFG_WD),
    .CPU_PIX_WE (CPU_PIX_WE),
    .CPU_PIX_WA (CPU_PIX_WA),
    .CPU_PIX_WD (CPU_PIX_WD),
    .FB_WE      (FB_WE),
    .FB_WA      (FB_WA),
    .FB_WD      (FB_WD),
    .BUSY       (BUSY),
    .PIX_CNT    (PIX_CNT),
    .DONE_IRQ   (DONE_IRQ)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp_e;
  bit sb_ignore = 1'b0;
  int wr_cnt = 0, busy_cyc = 0, irq_cnt = 0;
  int b_wr, b_busy, b_irq;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (BUSY) busy_cyc++;
      if (DONE_IRQ) irq_cnt++;
      if (FB_WE) begin
        wr_cnt++;
        if (!sb_ignore) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fb_unexpected: got wa=0x%0h wd=0x%0h expected no write", FB_WA, FB_WD);
          end else begin
            exp_e = exp_q.pop_front();
            chk("fb_write", int'({FB_WA, FB_WD}), int'(exp_e));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic [2:0] sel, input logic [15:0] d);
    CFG_SEL = sel;
    CFG_WD  = d;
    CFG_WE  = 1'b1;
    tick();
    CFG_WE  = 1'b0;
  endtask

  task automatic load(input int x0, input int y0, input int w, input int h, input int color);
    cfg(SEL_X0, 16'(x0));
    cfg(SEL_Y0, 16'(y0));
    cfg(SEL_W, 16'(w));
    cfg(SEL_H, 16'(h));
    cfg(SEL_COLOR, 16'(color));
  endtask

  task automatic push(input logic [14:0] wa, input logic [11:0] wd);
    exp_q.push_back({wa, wd});
  endtask

  task automatic snap();
    b_wr   = wr_cnt;
    b_busy = busy_cyc;
    b_irq  = irq_cnt;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && BUSY; i++) tick();
    if (BUSY) chk({tag, "_timeout"}, 1, 0);
    repeat (3) tick();
  endtask

  task automatic finish_test(input string tag, input int n_wr, input int n_busy,
                             input int n_irq, input int pc);
    wait_idle(tag);
    chk({tag, "_writes"}, wr_cnt - b_wr, n_wr);
    chk({tag, "_busy_cycles"}, busy_cyc - b_busy, n_busy);
    chk({tag, "_irq_pulses"}, irq_cnt - b_irq, n_irq);
    chk({tag, "_pix_cnt"}, int'(PIX_CNT), pc);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  initial begin
    RST_N = 1'b0;
    CFG_WE = 1'b0; CFG_SEL = '0; CFG_WD = '0;
    CPU_PIX_WE = 1'b0; CPU_PIX_WA = '0; CPU_PIX_WD = '0;
    repeat (3) tick();
    chk("rst_fb_we", int'(FB_WE), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_pix_cnt", int'(PIX_CNT), 0);
    chk("rst_irq", int'(DONE_IRQ), 0);
    RST_N = 1'b1;
    repeat (2) tick();

    // basic 3x2 fill
    load(10, 5, 3, 2, 'hF00);
    push(15'h050A, 12'hF00); push(15'h050B, 12'hF00); push(15'h050C, 12'hF00);
    push(15'h060A, 12'hF00); push(15'h060B, 12'hF00); push(15'h060C, 12'hF00);
    snap();
    cfg(SEL_CTRL, 16'h0001);
    finish_test("basic", 6, 7, IRQ_EXP, 6);

    // clipped at bottom-right corner
    load(158, 119, 5, 4, 'h0A5);
    push(15'h779E, 12'h0A5); push(15'h779F, 12'h0A5);
    snap();
    cfg(SEL_CTRL, 16'h0001);
    finish_test("clip", 2, 3, IRQ_EXP, 2);

    // CPU writes preempt three engine cycles
    load(20, 30, 4, 2, 'h123);
    push(15'h1E14, 12'h123); push(15'h1E15, 12'h123);
    push(15'h0000, 12'h0FF); push(15'h0000, 12'h0FF); push(15'h0000, 12'h0FF);
    push(15'h1E16, 12'h123); push(15'h1E17, 12'h123);
    push(15'h1F14, 12'h123); push(15'h1F15, 12'h123);
    push(15'h1F16, 12'h123); push(15'h1F17, 12'h123);
    snap();
    cfg(SEL_CTRL, 16'h0001);
    repeat (3) tick();
    CPU_PIX_WA = 15'h0000; CPU_PIX_WD = 12'h0FF; CPU_PIX_WE = 1'b1;
    repeat (3) tick();
    CPU_PIX_WE = 1'b0;
    finish_test("cpu_prio", 11, 12, IRQ_EXP, 8);

    // abort after four pixels, with an ignored GO during FILL
    load(0, 10, 10, 3, 'h0F0);
    push(15'h0A00, 12'h0F0); push(15'h0A01, 12'h0F0);
    push(15'h0A02, 12'h0F0); push(15'h0A03, 12'h0F0);
    snap();
    cfg(SEL_CTRL, 16'h0001);
    tick();
    cfg(SEL_CTRL, 16'h0001);
    repeat (3) tick();
    cfg(SEL_CTRL, 16'h0002);
    finish_test("abort", 4, 6, IRQ_EXP, 4);

    // empty rectangles
    load(5, 5, 0, 4, 'hABC);
    snap();
    cfg(SEL_CTRL, 16'h0001);
    finish_test("w_zero", 0, 1, IRQ_EXP, 0);

    load(0, 120, 5, 5, 'hABC);
    snap();
    cfg(SEL_CTRL, 16'h0001);
    finish_test("y_off", 0, 1, IRQ_EXP, 0);

    // GO and ABORT together: nothing starts
    load(0, 0, 4, 4, 'h111);
    snap();
    cfg(SEL_CTRL, 16'h0003);
    repeat (6) tick();
    chk("go_abort_writes", wr_cnt - b_wr, 0);
    chk("go_abort_busy", busy_cyc - b_busy, 0);

    // reset asserted mid-fill
    load(0, 0, 100, 50, 'h777);
    sb_ignore = 1'b1;
    cfg(SEL_CTRL, 16'h0001);
    repeat (4) tick();
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_fb_we", int'(FB_WE), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_pix_cnt", int'(PIX_CNT), 0);
    chk("midrst_fb_wa", int'(FB_WA), 0);
    repeat (2) tick();
    RST_N = 1'b1;
    snap();
    repeat (20) tick();
    chk("postrst_writes", wr_cnt - b_wr, 0);
    chk("postrst_busy", busy_cyc - b_busy, 0);
    sb_ignore = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
